// File: rtl/exc_commit_ctrl.sv
// Dual-issue commit-stage exception controller.
// Selects the oldest exception, writes CP0, then flushes and redirects fetch.
module exc_commit_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid1_i,
  input  logic        valid2_i,
  input  logic [31:0] excepttype1_i,
  input  logic [31:0] excepttype2_i,
  input  logic [31:0] pc1_i,
  input  logic [31:0] pc2_i,
  input  logic        ds1_i,
  input  logic        ds2_i,
  input  logic [31:0] badaddr1_i,
  input  logic [31:0] badaddr2_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        stall_i,
  output logic        exc_valid_o,
  output logic [31:0] exc_type_o,
  output logic [31:0] exc_pc_o,
  output logic [31:0] exc_badaddr_o,
  output logic        exc_ds_o,
  output logic        kill2_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  localparam logic [31:0] ERET    = 32'h0000_000E;
  localparam logic [31:0] INT     = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        irq;
  logic [31:0] code1, code2;
  logic        has1, has2, take;
  logic [31:0] sel_type, sel_pc, sel_bad;
  logic        sel_ds;
  logic [31:0] rpc_q, rpc_tgt;
  logic        unused_bits;

  assign unused_bits = ^{cause_i[31:16], cause_i[7:0],
                         status_i[31:16], status_i[7:2]};

  function automatic logic recog(input logic [31:0] c);
    unique case (c)
      32'h1, 32'h4, 32'h5, 32'h8, 32'h9,
      32'hA, 32'hC, 32'hD, 32'hE: recog = 1'b1;
      default:                    recog = 1'b0;
    endcase
  endfunction

  // Interrupt injection and slot priority selection
  always_comb begin
    irq = status_i[0] & ~status_i[1] &
          (|(cause_i[15:8] & status_i[15:8]));
    code1 = (irq && valid1_i) ? INT : excepttype1_i;
    code2 = (irq && !valid1_i && valid2_i) ? INT : excepttype2_i;
    has1 = valid1_i & recog(code1);
    has2 = valid2_i & recog(code2);
    take = (state == IDLE) & ~stall_i & (has1 | has2);
    if (has1) begin
      sel_type = code1;
      sel_pc   = pc1_i;
      sel_ds   = ds1_i;
      sel_bad  = badaddr1_i;
    end else begin
      sel_type = code2;
      sel_pc   = pc2_i;
      sel_ds   = ds2_i;
      sel_bad  = badaddr2_i;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (take) state_nxt = COMMIT;
      COMMIT:   state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode; epc_i is read live in REDIRECT
  always_comb begin
    exc_valid_o   = (state == COMMIT);
    redirect_o    = (state == REDIRECT);
    flush_o       = (state == COMMIT) | (state == REDIRECT);
    busy_o        = (state != IDLE);
    kill2_o       = (state == IDLE) & ~stall_i & has1;
    rpc_tgt       = (exc_type_o == ERET) ? epc_i : EXC_VEC;
    redirect_pc_o = (state == REDIRECT) ? rpc_tgt : rpc_q;
  end

  // Exception record latch on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_type_o    <= '0;
      exc_pc_o      <= '0;
      exc_badaddr_o <= '0;
      exc_ds_o      <= 1'b0;
    end else if (take) begin
      exc_type_o    <= sel_type;
      exc_pc_o      <= sel_pc;
      exc_badaddr_o <= sel_bad;
      exc_ds_o      <= sel_ds;
    end
  end

  // Redirect target hold register
  always_ff @(posedge clk) begin
    if (rst)                    rpc_q <= EXC_VEC;
    else if (state == REDIRECT) rpc_q <= rpc_tgt;
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed testbench for exc_commit_ctrl.
// Vector table for single exceptions plus hand-written corner sequences.
module tb_exc_commit_ctrl;

  logic        clk = 0;
  logic        rst;
  logic        valid1_i, valid2_i;
  logic [31:0] excepttype1_i, excepttype2_i;
  logic [31:0] pc1_i, pc2_i;
  logic        ds1_i, ds2_i;
  logic [31:0] badaddr1_i, badaddr2_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        stall_i;
  logic        exc_valid_o;
  logic [31:0] exc_type_o, exc_pc_o, exc_badaddr_o;
  logic        exc_ds_o, kill2_o, flush_o, redirect_o, busy_o;
  logic [31:0] redirect_pc_o;

  exc_commit_ctrl dut (
    .clk(clk), .rst(rst),
    .valid1_i(valid1_i), .valid2_i(valid2_i),
    .excepttype1_i(excepttype1_i), .excepttype2_i(excepttype2_i),
    .pc1_i(pc1_i), .pc2_i(pc2_i),
    .ds1_i(ds1_i), .ds2_i(ds2_i),
    .badaddr1_i(badaddr1_i), .badaddr2_i(badaddr2_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .stall_i(stall_i),
    .exc_valid_o(exc_valid_o), .exc_type_o(exc_type_o),
    .exc_pc_o(exc_pc_o), .exc_badaddr_o(exc_badaddr_o),
    .exc_ds_o(exc_ds_o), .kill2_o(kill2_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] PC1  = 32'h8000_1000;
  localparam logic [31:0] PC2  = 32'h8000_1004;
  localparam logic [31:0] BAD1 = 32'h1111_0000;
  localparam logic [31:0] BAD2 = 32'h8000_2003;
  localparam logic [31:0] EPC  = 32'h8000_3000;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;

  typedef struct {
    logic        v1, v2;
    logic [31:0] t1, t2;
    logic        d1, d2;
    logic [31:0] st, ca;
    logic        e_kill, e_start;
    logic [31:0] e_type, e_pc, e_bad;
    logic        e_ds;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vt[12];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid1_i = 0; valid2_i = 0;
    excepttype1_i = 0; excepttype2_i = 0;
    ds1_i = 0; ds2_i = 0;
    status_i = 0; cause_i = 0;
    stall_i = 0;
  endtask

  initial begin
    pc1_i = PC1; pc2_i = PC2;
    badaddr1_i = BAD1; badaddr2_i = BAD2;
    epc_i = EPC;
    idle_in();

    //      v1 v2 t1     t2     d1 d2 status        cause        kill st type   pc   bad   ds rpc
    vt[0]  = '{1, 0, 32'h8, 32'h0, 0, 0, 32'h0,      32'h0,       1, 1, 32'h8, PC1, BAD1, 0, VEC};
    vt[1]  = '{1, 1, 32'h0, 32'h4, 0, 1, 32'h0,      32'h0,       0, 1, 32'h4, PC2, BAD2, 1, VEC};
    vt[2]  = '{1, 0, 32'hE, 32'h0, 0, 0, 32'h0,      32'h0,       1, 1, 32'hE, PC1, BAD1, 0, EPC};
    vt[3]  = '{1, 0, 32'h0, 32'h0, 0, 0, 32'hFF01,   32'h100,     1, 1, 32'h1, PC1, BAD1, 0, VEC};
    vt[4]  = '{1, 0, 32'h0, 32'h0, 0, 0, 32'hFF03,   32'h100,     0, 0, 32'h0, 0,   0,    0, 0};
    vt[5]  = '{0, 1, 32'h8, 32'h0, 0, 0, 32'h0,      32'h0,       0, 0, 32'h0, 0,   0,    0, 0};
    vt[6]  = '{1, 0, 32'h3, 32'h0, 0, 0, 32'h0,      32'h0,       0, 0, 32'h0, 0,   0,    0, 0};
    vt[7]  = '{1, 1, 32'h7, 32'hD, 0, 1, 32'h0,      32'h0,       0, 1, 32'hD, PC2, BAD2, 1, VEC};
    vt[8]  = '{0, 1, 32'h0, 32'h0, 0, 0, 32'h0401,   32'h400,     0, 1, 32'h1, PC2, BAD2, 0, VEC};
    vt[9]  = '{1, 1, 32'h5, 32'hC, 1, 0, 32'h0,      32'h0,       1, 1, 32'h5, PC1, BAD1, 1, VEC};
    vt[10] = '{1, 0, 32'hA, 32'h0, 0, 0, 32'hFF01,   32'h8000,    1, 1, 32'h1, PC1, BAD1, 0, VEC};
    vt[11] = '{1, 0, 32'h0, 32'h0, 0, 0, 32'hFF01,   32'h0,       0, 0, 32'h0, 0,   0,    0, 0};

    rst = 1;
    tick(); tick();
    chk("rst_exc_valid", {31'b0, exc_valid_o}, 0);
    chk("rst_redirect", {31'b0, redirect_o}, 0);
    chk("rst_flush", {31'b0, flush_o}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_exc_type", exc_type_o, 0);
    chk("rst_rpc", redirect_pc_o, VEC);
    rst = 0;
    tick();
    chk("post_rst_exc_valid", {31'b0, exc_valid_o}, 0);
    chk("post_rst_redirect", {31'b0, redirect_o}, 0);

    for (int i = 0; i < 12; i++) begin
      valid1_i = vt[i].v1; valid2_i = vt[i].v2;
      excepttype1_i = vt[i].t1; excepttype2_i = vt[i].t2;
      ds1_i = vt[i].d1; ds2_i = vt[i].d2;
      status_i = vt[i].st; cause_i = vt[i].ca;
      #1;
      chk($sformatf("v%0d_kill2", i), {31'b0, kill2_o}, {31'b0, vt[i].e_kill});
      tick();
      idle_in();
      chk($sformatf("v%0d_exc_valid", i), {31'b0, exc_valid_o}, {31'b0, vt[i].e_start});
      if (vt[i].e_start) begin
        chk($sformatf("v%0d_flush_c", i), {31'b0, flush_o}, 1);
        chk($sformatf("v%0d_type", i), exc_type_o, vt[i].e_type);
        chk($sformatf("v%0d_pc", i), exc_pc_o, vt[i].e_pc);
        chk($sformatf("v%0d_bad", i), exc_badaddr_o, vt[i].e_bad);
        chk($sformatf("v%0d_ds", i), {31'b0, exc_ds_o}, {31'b0, vt[i].e_ds});
        tick();
        chk($sformatf("v%0d_redirect", i), {31'b0, redirect_o}, 1);
        chk($sformatf("v%0d_exc_valid_r", i), {31'b0, exc_valid_o}, 0);
        chk($sformatf("v%0d_rpc", i), redirect_pc_o, vt[i].e_rpc);
        tick();
        chk($sformatf("v%0d_idle_busy", i), {31'b0, busy_o}, 0);
        chk($sformatf("v%0d_rpc_hold", i), redirect_pc_o, vt[i].e_rpc);
        chk($sformatf("v%0d_type_hold", i), exc_type_o, vt[i].e_type);
      end else begin
        chk($sformatf("v%0d_busy", i), {31'b0, busy_o}, 0);
      end
    end

    // Stall blocks acceptance; exceptions while busy are ignored
    valid1_i = 1; excepttype1_i = 32'h8; stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_kill2", k), {31'b0, kill2_o}, 0);
      tick();
      chk($sformatf("stall%0d_busy", k), {31'b0, busy_o}, 0);
    end
    stall_i = 0;
    #1;
    chk("unstall_kill2", {31'b0, kill2_o}, 1);
    tick();
    chk("unstall_exc_valid", {31'b0, exc_valid_o}, 1);
    excepttype1_i = 32'h9; pc1_i = 32'h8000_5000; stall_i = 1;
    #1;
    chk("commit_kill2", {31'b0, kill2_o}, 0);
    tick();
    chk("second_redirect", {31'b0, redirect_o}, 1);
    chk("second_type_held", exc_type_o, 32'h8);
    chk("second_pc_held", exc_pc_o, PC1);
    stall_i = 0;
    tick();
    chk("after_redirect_busy", {31'b0, busy_o}, 0);
    chk("after_redirect_exc_valid", {31'b0, exc_valid_o}, 0);
    chk("after_redirect_kill2", {31'b0, kill2_o}, 1);
    tick();
    idle_in();
    chk("late_exc_valid", {31'b0, exc_valid_o}, 1);
    chk("late_type", exc_type_o, 32'h9);
    chk("late_pc", exc_pc_o, 32'h8000_5000);
    tick(); tick();
    pc1_i = PC1;

    // Reset in COMMIT aborts the sequence
    valid1_i = 1; excepttype1_i = 32'h4;
    tick();
    idle_in();
    chk("pre_rst_exc_valid", {31'b0, exc_valid_o}, 1);
    rst = 1;
    tick();
    chk("mid_rst_exc_valid", {31'b0, exc_valid_o}, 0);
    chk("mid_rst_redirect", {31'b0, redirect_o}, 0);
    chk("mid_rst_flush", {31'b0, flush_o}, 0);
    chk("mid_rst_busy", {31'b0, busy_o}, 0);
    chk("mid_rst_type", exc_type_o, 0);
    chk("mid_rst_rpc", redirect_pc_o, VEC);
    rst = 0;
    tick();
    chk("rel_redirect", {31'b0, redirect_o}, 0);
    chk("rel_exc_valid", {31'b0, exc_valid_o}, 0);
    tick();
    chk("rel2_redirect", {31'b0, redirect_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
